acquisition_sequencer: RTL and testbench
========================================

ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the acquisition count and completed-acquisition counter.
REQ-002 Parameter TO_WIDTH, default 32: width of the timeout counter and timeout_i.
REQ-003 stream_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 stream_reset  in  1  synchronous, active-high reset.
REQ-005 run_i  in  1  request to begin a sequence; sampled only in S_IDLE.
REQ-006 abort_i  in  1  terminate the sequence; sampled in every non-idle state.
REQ-007 acq_count_i  in  CNT_WIDTH  acquisitions per sequence; 0 = continuous until abort or timeout.
REQ-008 timeout_i  in  TO_WIDTH  per-acquisition cycle limit; 0 = timeout disabled.
REQ-009 dma_ready_i  in  1  downstream buffer is armed for the next acquisition.
REQ-010 injector_idle_i  in  1  idle status from the trigger/tlast injector, already synchronised to stream_clk.
REQ-011 injector_start_o  out  1  start level driven to the injector.
REQ-012 dma_rearm_o  out  1  single-cycle pulse on each completed acquisition.
REQ-013 busy_o  out  1  high in every state except S_IDLE.
REQ-014 done_o  out  1  sticky; the sequence completed all requested acquisitions.
REQ-015 timeout_o  out  1  sticky; the sequence was ended by timeout.
REQ-016 acq_done_o  out  CNT_WIDTH  number of acquisitions completed in the current or last sequence.
REQ-017 state_o  out  3  current state encoding, for debug.

Function
REQ-018 States, encoded as S_IDLE=0, S_ARM=1, S_START=2, S_RUN=3, S_DONE=4; any other encoding SHALL go to S_IDLE on the next cycle.
REQ-019 injector_start_o SHALL equal (state==S_START) and busy_o SHALL equal (state!=S_IDLE); both are decoded from the state register with no combinational path from inputs.
REQ-020 S_IDLE with run_i=1:
- next state S_ARM;
- latch acq_count_i into an internal target register;
- clear acq_done_o, done_o and timeout_o.
REQ-021 S_ARM: go to S_START when dma_ready_i=1; otherwise hold. The timeout counter does not run in S_ARM.
REQ-022 S_START: go to S_RUN when injector_idle_i=0; otherwise hold with injector_start_o high.
REQ-023 S_RUN, on injector_idle_i=1:
- increment acq_done_o;
- pulse dma_rearm_o for exactly one cycle;
- next state S_DONE if target!=0 and acq_done_o+1==target, else S_ARM.
REQ-024 S_DONE: set done_o and go to S_IDLE on the next cycle.
REQ-025 Timeout counter:
- cleared on every entry to S_START;
- increments each cycle in S_START and S_RUN;
- when timeout_i!=0 and the count equals timeout_i-1, set timeout_o and go to S_IDLE without incrementing acq_done_o.
REQ-026 abort_i=1 in any non-idle state SHALL send the block to S_IDLE on the next cycle, with no increment, no dma_rearm_o pulse, and done_o left clear.
REQ-027 Event priority within one cycle: abort > timeout > completion.
REQ-028 run_i outside S_IDLE SHALL be ignored.
REQ-029 In continuous mode acq_done_o SHALL wrap modulo 2^CNT_WIDTH; changes to acq_count_i while busy SHALL have no effect.
REQ-030 Latency: run_i high in cycle n with dma_ready_i high and no abort SHALL give state S_ARM in cycle n+1 and injector_start_o high in cycle n+2.

Reset
REQ-031 While stream_reset=1 at a clock edge, the block SHALL load:
- state S_IDLE;
- injector_start_o=0, dma_rearm_o=0, busy_o=0, done_o=0, timeout_o=0;
- acq_done_o=0, target=0, timeout counter=0.
REQ-032 Reset asserted mid-sequence SHALL take effect on that edge, overriding all other events, and drop injector_start_o on the next cycle.

Verification
REQ-033 acq_count_i=3, timeout_i=0, dma_ready_i=1, injector model idle low 5 cycles after start, high 100 cycles later -> exactly 3 start assertions, 3 dma_rearm_o pulses, acq_done_o=3, done_o=1, busy_o=0.
REQ-034 acq_count_i=2, dma_ready_i held low 50 cycles after the first rearm -> state stays S_ARM and injector_start_o=0 throughout the 50 cycles; the second acquisition completes afterwards.
REQ-035 timeout_i=20, injector idle never deasserts -> timeout_o=1 and state S_IDLE exactly 20 cycles after S_START entry, acq_done_o=0, done_o=0.
REQ-036 acq_count_i=0, abort_i pulsed on the same cycle as a completion -> no dma_rearm_o pulse, acq_done_o unchanged, S_IDLE next cycle, done_o=0.
REQ-037 stream_reset pulsed during S_RUN -> all outputs at reset values on the next cycle; a subsequent run_i starts normally with acq_done_o=0.
REQ-038 run_i pulsed during S_RUN and acq_count_i changed 1->5 while busy -> both ignored; the sequence ends after the latched count of 1.

Source files
------------

// File: rtl/acquisition_sequencer.sv
`default_nettype none
// ============================================================================
// acquisition_sequencer - arms DMA, starts the injector, counts acquisitions.
// Rev 1.0
// ============================================================================
module acquisition_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int TO_WIDTH  = 32
) (
  input  logic                 stream_clk,
  input  logic                 stream_reset,
  input  logic                 run_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] acq_count_i,
  input  logic [TO_WIDTH-1:0]  timeout_i,
  input  logic                 dma_ready_i,
  input  logic                 injector_idle_i,
  output logic                 injector_start_o,
  output logic                 dma_rearm_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] acq_done_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0] acq_done_q, acq_done_d;
  logic [TO_WIDTH-1:0]  tcnt_q, tcnt_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 rearm_q, rearm_d;
  logic [CNT_WIDTH-1:0] acq_next;
  logic                 to_hit;

  assign acq_next = acq_done_q + CNT_WIDTH'(1);
  assign to_hit   = (timeout_i != '0) && (tcnt_q == timeout_i - TO_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    acq_done_d = acq_done_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    rearm_d    = 1'b0;
    tcnt_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d    = S_ARM;
          target_d   = acq_count_i;
          acq_done_d = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (abort_i)          state_d = S_IDLE;
        else if (dma_ready_i) state_d = S_START;
      end
      S_START, S_RUN: begin
        // Counter is zero on entry to S_START because every other state clears it.
        tcnt_d = tcnt_q + TO_WIDTH'(1);
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (state_q == S_START) begin
          if (!injector_idle_i) state_d = S_RUN;
        end else if (injector_idle_i) begin
          acq_done_d = acq_next;
          rearm_d    = 1'b1;
          state_d    = ((target_q != '0) && (acq_next == target_q)) ? S_DONE : S_ARM;
        end
      end
      S_DONE: begin
        if (!abort_i) done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge stream_clk) begin
    if (stream_reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      acq_done_q <= '0;
      tcnt_q     <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rearm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      acq_done_q <= acq_done_d;
      tcnt_q     <= tcnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      rearm_q    <= rearm_d;
    end
  end

  assign injector_start_o = (state_q == S_START);
  assign busy_o           = (state_q != S_IDLE);
  assign dma_rearm_o      = rearm_q;
  assign done_o           = done_q;
  assign timeout_o        = timeout_q;
  assign acq_done_o       = acq_done_q;
  assign state_o          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_acquisition_sequencer.sv
`default_nettype none
// ============================================================================
// tb_acquisition_sequencer - directed scenarios plus random traffic vs model.
// Rev 1.0
// ============================================================================
module tb_acquisition_sequencer;

  localparam int CW   = 4;
  localparam int TW   = 8;
  localparam int CMOD = 1 << CW;
  localparam int TMOD = 1 << TW;
  localparam int ST_IDLE = 0, ST_ARM = 1, ST_START = 2, ST_RUN = 3, ST_DONE = 4;

  logic          stream_clk = 1'b0;
  logic          stream_reset, run_i, abort_i, dma_ready_i, injector_idle_i;
  logic [CW-1:0] acq_count_i;
  logic [TW-1:0] timeout_i;
  logic          injector_start_o, dma_rearm_o, busy_o, done_o, timeout_o;
  logic [CW-1:0] acq_done_o;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_pass   = 0;

  int m_state = 0, m_target = 0, m_acq = 0, m_elapsed = 0;
  bit m_done = 0, m_to = 0, m_rearm = 0;

  int n_starts = 0, n_rearms = 0;
  bit prev_start = 0;
  bit inj_auto = 0;
  int inj_phase = 0, inj_t = 0, inj_lo_dly = 5, inj_hi_dly = 100;

  acquisition_sequencer #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
    .stream_clk      (stream_clk),
    .stream_reset    (stream_reset),
    .run_i           (run_i),
    .abort_i         (abort_i),
    .acq_count_i     (acq_count_i),
    .timeout_i       (timeout_i),
    .dma_ready_i     (dma_ready_i),
    .injector_idle_i (injector_idle_i),
    .injector_start_o(injector_start_o),
    .dma_rearm_o     (dma_rearm_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .timeout_o       (timeout_o),
    .acq_done_o      (acq_done_o),
    .state_o         (state_o)
  );

  always #5 stream_clk = ~stream_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Sequence rules applied to the inputs present before the coming edge.
  task automatic model_step();
    int ns;
    ns      = m_state;
    m_rearm = 0;
    if (stream_reset) begin
      ns = ST_IDLE; m_target = 0; m_acq = 0; m_done = 0; m_to = 0; m_elapsed = 0;
    end else begin
      case (m_state)
        ST_IDLE: if (run_i) begin
          ns = ST_ARM; m_target = int'(acq_count_i); m_acq = 0; m_done = 0; m_to = 0;
        end
        ST_ARM: begin
          if (abort_i)          ns = ST_IDLE;
          else if (dma_ready_i) ns = ST_START;
        end
        ST_START, ST_RUN: begin
          if (abort_i) ns = ST_IDLE;
          else if (timeout_i != 0 && m_elapsed + 1 == int'(timeout_i)) begin
            m_to = 1; ns = ST_IDLE;
          end else if (m_state == ST_START) begin
            if (!injector_idle_i) ns = ST_RUN;
          end else if (injector_idle_i) begin
            m_acq   = (m_acq + 1) % CMOD;
            m_rearm = 1;
            ns      = (m_target != 0 && m_acq == m_target) ? ST_DONE : ST_ARM;
          end
        end
        ST_DONE: begin
          if (!abort_i) m_done = 1;
          ns = ST_IDLE;
        end
        default: ns = ST_IDLE;
      endcase
      if (ns == ST_START && m_state == ST_ARM) m_elapsed = 0;
      else m_elapsed = (m_elapsed + 1) % TMOD;
    end
    m_state = ns;
  endtask

  task automatic tick();
    model_step();
    @(posedge stream_clk);
    #1;
    check("state",    state_o,          m_state);
    check("start",    injector_start_o, (m_state == ST_START));
    check("busy",     busy_o,           (m_state != ST_IDLE));
    check("rearm",    dma_rearm_o,      m_rearm);
    check("done",     done_o,           m_done);
    check("timeout",  timeout_o,        m_to);
    check("acq_done", acq_done_o,       m_acq);
    if (injector_start_o && !prev_start) n_starts++;
    prev_start = injector_start_o;
    if (dma_rearm_o) n_rearms++;
    if (inj_auto) begin
      if (inj_phase == 0 && injector_start_o) begin inj_phase = 1; inj_t = 0; end
      if (inj_phase == 1) begin
        inj_t++;
        if (inj_t >= inj_lo_dly) begin injector_idle_i = 1'b0; inj_phase = 2; inj_t = 0; end
      end else if (inj_phase == 2) begin
        inj_t++;
        if (inj_t >= inj_hi_dly) begin injector_idle_i = 1'b1; inj_phase = 0; end
      end
    end
  endtask

  task automatic clear_stats();
    n_starts = 0; n_rearms = 0; inj_phase = 0; inj_t = 0; injector_idle_i = 1'b1;
  endtask

  task automatic pulse_run();
    run_i = 1'b1; tick(); run_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy_o && i < budget) begin tick(); i++; end
    check(tag, busy_o, 0);
  endtask

  task automatic wait_rearms(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (n_rearms < n && i < budget) begin tick(); i++; end
    check(tag, n_rearms, n);
  endtask

  initial begin
    int ok;
    stream_reset = 1'b1; run_i = 1'b0; abort_i = 1'b0; dma_ready_i = 1'b1;
    injector_idle_i = 1'b1; acq_count_i = '0; timeout_i = '0;
    tick(); tick();
    stream_reset = 1'b0;

    // Three acquisitions with a slow injector; first-run latency checked explicitly.
    acq_count_i = CW'(3); inj_auto = 1; inj_lo_dly = 5; inj_hi_dly = 100; clear_stats();
    pulse_run();
    check("lat_arm", state_o, ST_ARM);
    tick();
    check("lat_start", injector_start_o, 1);
    wait_idle("s1_idle", 2000);
    check("s1_starts", n_starts, 3);
    check("s1_rearms", n_rearms, 3);
    check("s1_acq", acq_done_o, 3);
    check("s1_done", done_o, 1);

    // DMA not ready for 50 cycles after the first rearm.
    acq_count_i = CW'(2); inj_lo_dly = 3; inj_hi_dly = 10; clear_stats();
    pulse_run();
    wait_rearms("s2_first", 1, 500);
    dma_ready_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state_o == 3'(ST_ARM) && !injector_start_o) ok++;
    end
    check("s2_hold", ok, 50);
    dma_ready_i = 1'b1;
    wait_idle("s2_idle", 500);
    check("s2_acq", acq_done_o, 2);
    check("s2_done", done_o, 1);

    // Timeout with injector stuck idle.
    inj_auto = 0; clear_stats(); acq_count_i = CW'(1); timeout_i = TW'(20);
    pulse_run();
    tick();
    check("s3_entry", state_o, ST_START);
    repeat (19) tick();
    check("s3_pre", state_o, ST_START);
    tick();
    check("s3_state", state_o, ST_IDLE);
    check("s3_to", timeout_o, 1);
    check("s3_acq", acq_done_o, 0);
    check("s3_done", done_o, 0);

    // Continuous mode: abort lands on a completion cycle.
    timeout_i = '0; acq_count_i = '0;
    pulse_run();
    tick();
    injector_idle_i = 1'b0; tick(); tick(); tick();
    injector_idle_i = 1'b1; tick();
    check("s4_first", acq_done_o, 1);
    tick();
    injector_idle_i = 1'b0; tick();
    check("s4_run", state_o, ST_RUN);
    injector_idle_i = 1'b1; abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("s4_state", state_o, ST_IDLE);
    check("s4_rearm", dma_rearm_o, 0);
    check("s4_acq", acq_done_o, 1);
    check("s4_done", done_o, 0);

    // Reset in the middle of a run, then a clean restart.
    acq_count_i = CW'(2);
    pulse_run();
    tick();
    injector_idle_i = 1'b0; tick();
    stream_reset = 1'b1; tick(); stream_reset = 1'b0;
    check("s5_state", state_o, ST_IDLE);
    check("s5_start", injector_start_o, 0);
    check("s5_acq", acq_done_o, 0);
    injector_idle_i = 1'b1; acq_count_i = CW'(1);
    pulse_run();
    check("s5_restart", state_o, ST_ARM);
    check("s5_acq0", acq_done_o, 0);
    inj_auto = 1; inj_lo_dly = 2; inj_hi_dly = 4; clear_stats();
    wait_idle("s5_idle", 200);
    check("s5_done", done_o, 1);

    // run_i and a new count while busy are ignored.
    inj_auto = 0; clear_stats(); acq_count_i = CW'(1);
    pulse_run();
    tick();
    injector_idle_i = 1'b0; tick();
    run_i = 1'b1; acq_count_i = CW'(5); tick(); run_i = 1'b0;
    injector_idle_i = 1'b1; tick();
    wait_idle("s6_idle", 50);
    check("s6_acq", acq_done_o, 1);
    check("s6_done", done_o, 1);

    // Continuous mode wraps the completed counter.
    acq_count_i = '0; inj_auto = 1; inj_lo_dly = 1; inj_hi_dly = 1; clear_stats();
    pulse_run();
    wait_rearms("s7_count", CMOD + 1, 1000);
    check("s7_wrap", acq_done_o, 1);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("s7_abort", busy_o, 0);

    // Random traffic against the model.
    inj_auto = 0;
    for (int c = 0; c < 4000; c++) begin
      run_i        = ($urandom_range(0, 3) == 0);
      abort_i      = ($urandom_range(0, 49) == 0);
      dma_ready_i  = ($urandom_range(0, 3) != 0);
      stream_reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) injector_idle_i = ~injector_idle_i;
      acq_count_i  = CW'($urandom_range(0, 5));
      if (state_o == 3'(ST_IDLE))
        timeout_i = ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(3, 30));
      tick();
    end
    stream_reset = 1'b0; run_i = 1'b0; abort_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
